inst_align_buffer: RTL and testbench

//  Fetch-side realignment buffer feeding the decompression unit.
//  - Accepts 32-bit word-aligned fetch words.
//  - Emits one instruction per handshake: a 16-bit compressed parcel (zero-extended) or a full 32-bit instruction.
//  - Handles 32-bit instructions that straddle a word boundary, and redirects to halfword-aligned targets.

---
 rtl/inst_align_if.sv | 24 ++
 rtl/inst_align_buffer.sv | 89 ++++++++
 tb/tb_inst_align_buffer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/inst_align_if.sv
// Fetch-side and consumer-side handshake bundle for the instruction realignment buffer.
interface inst_align_if;
  logic        flush;
  logic [31:0] flush_pc;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_is_c;
  logic [31:0] out_pc;

  modport slave (
    input  flush, flush_pc, in_valid, in_word, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_is_c, out_pc
  );

  modport master (
    output flush, flush_pc, in_valid, in_word, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_is_c, out_pc
  );
endinterface

// File: rtl/inst_align_buffer.sv
// Realigns word-aligned fetch data into one 16- or 32-bit instruction per handshake,
// using a 4-entry halfword queue with support for halfword-aligned redirect targets.
module inst_align_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst_n,
  inst_align_if.slave  bus
);

  typedef enum logic {StNormal, StSkipLow} state_e;

  state_e      state_q, state_d;
  logic [15:0] hw_q [4];
  logic [15:0] hw_d [4];
  logic [15:0] hw_s [4];
  logic [2:0]  cnt_q, cnt_d, cnt_pop;
  logic [31:0] head_q, head_d;
  logic        is_c, valid, pop, push;
  logic [2:0]  pop_n;
  logic [1:0]  idx0, idx1;

  assign is_c  = hw_q[0][1:0] != 2'b11;
  assign valid = (cnt_q >= 3'd1 && is_c) || (cnt_q >= 3'd2);

  // Data outputs are forced to zero while invalid so the reset values are well defined.
  assign bus.out_valid = valid;
  assign bus.out_is_c  = valid & is_c;
  assign bus.out_inst  = !valid ? 32'h0 : (is_c ? {16'h0, hw_q[0]} : {hw_q[1], hw_q[0]});
  assign bus.out_pc    = head_q;
  assign bus.in_ready  = (cnt_q <= 3'd2) && !bus.flush;

  always_comb begin
    pop     = valid & bus.out_ready & ~bus.flush;
    push    = bus.in_valid & bus.in_ready;
    pop_n   = !pop ? 3'd0 : (is_c ? 3'd1 : 3'd2);
    cnt_pop = cnt_q - pop_n;
    idx0    = cnt_pop[1:0];
    idx1    = cnt_pop[1:0] + 2'd1;

    case (pop_n)
      3'd1:    hw_s = '{hw_q[1], hw_q[2], hw_q[3], 16'h0};
      3'd2:    hw_s = '{hw_q[2], hw_q[3], 16'h0, 16'h0};
      default: hw_s = hw_q;
    endcase

    hw_d    = hw_s;
    cnt_d   = cnt_pop;
    head_d  = head_q + {28'h0, pop_n, 1'b0};
    state_d = state_q;

    // Pop has already been applied; the push appends behind whatever remains.
    if (push) begin
      if (state_q == StSkipLow) begin
        hw_d[idx0] = bus.in_word[31:16];
        cnt_d      = cnt_pop + 3'd1;
        state_d    = StNormal;
      end else begin
        hw_d[idx0] = bus.in_word[15:0];
        hw_d[idx1] = bus.in_word[31:16];
        cnt_d      = cnt_pop + 3'd2;
      end
      if (cnt_pop == 3'd0) begin
        head_d = bus.in_pc + ((state_q == StSkipLow) ? 32'd2 : 32'd0);
      end
    end

    if (bus.flush) begin
      cnt_d   = 3'd0;
      head_d  = bus.flush_pc;
      state_d = bus.flush_pc[1] ? StSkipLow : StNormal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hw_q    <= '{default: 16'h0};
      cnt_q   <= 3'd0;
      head_q  <= RESET_PC;
      state_q <= RESET_PC[1] ? StSkipLow : StNormal;
    end else begin
      hw_q    <= hw_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_inst_align_buffer.sv
// Directed, table-driven bench for inst_align_buffer with hand-computed expectations.
module tb_inst_align_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  inst_align_if bus ();

  inst_align_buffer #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        flush;
    logic [31:0] flush_pc;
    logic        in_valid;
    logic [31:0] in_word;
    logic [31:0] in_pc;
    logic        out_ready;
    logic        e_valid;
    logic [31:0] e_inst;
    logic        e_c;
    logic [31:0] e_pc;
    logic        e_rdy;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(logic fl, logic [31:0] fpc, logic iv, logic [31:0] w,
                              logic [31:0] ipc, logic ordy, logic ev, logic [31:0] ei,
                              logic ec, logic [31:0] epc, logic erdy);
    vec_t v;
    v.flush = fl; v.flush_pc = fpc; v.in_valid = iv; v.in_word = w; v.in_pc = ipc;
    v.out_ready = ordy; v.e_valid = ev; v.e_inst = ei; v.e_c = ec; v.e_pc = epc;
    v.e_rdy = erdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check pre-edge outputs, then advance past the clock edge.
  task automatic apply(input vec_t v, input string tag);
    bus.flush     = v.flush;
    bus.flush_pc  = v.flush_pc;
    bus.in_valid  = v.in_valid;
    bus.in_word   = v.in_word;
    bus.in_pc     = v.in_pc;
    bus.out_ready = v.out_ready;
    #1;
    chk({tag, "_in_ready"}, {31'h0, bus.in_ready}, {31'h0, v.e_rdy});
    chk({tag, "_out_valid"}, {31'h0, bus.out_valid}, {31'h0, v.e_valid});
    if (v.e_valid) begin
      chk({tag, "_out_inst"}, bus.out_inst, v.e_inst);
      chk({tag, "_out_is_c"}, {31'h0, bus.out_is_c}, {31'h0, v.e_c});
      chk({tag, "_out_pc"}, bus.out_pc, v.e_pc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy, input logic ev, input logic [31:0] ei, input logic ec,
                      input logic [31:0] epc, input logic erdy, input string tag);
    apply(mk(0, 0, 0, 0, 0, ordy, ev, ei, ec, epc, erdy), tag);
  endtask

  initial begin
    bus.flush = 0; bus.flush_pc = 0; bus.in_valid = 0; bus.in_word = 0; bus.in_pc = 0;
    bus.out_ready = 0;

    //          fl fpc         iv word           pc            rdy ev inst          c pc          ir
    tbl[0]  = mk(0, 0,          1, 32'h00A00093, 32'h0,        1, 0, 0,            0, 0,          1);
    tbl[1]  = mk(0, 0,          1, 32'h00B00113, 32'h4,        1, 1, 32'h00A00093, 0, 32'h0,      1);
    tbl[2]  = mk(0, 0,          0, 0,            0,            1, 1, 32'h00B00113, 0, 32'h4,      1);
    tbl[3]  = mk(0, 0,          0, 0,            0,            1, 0, 0,            0, 0,          1);
    tbl[4]  = mk(0, 0,          1, 32'h45014505, 32'h10,       1, 0, 0,            0, 0,          1);
    tbl[5]  = mk(0, 0,          0, 0,            0,            1, 1, 32'h00004505, 1, 32'h10,     1);
    tbl[6]  = mk(0, 0,          0, 0,            0,            1, 1, 32'h00004501, 1, 32'h12,     1);
    tbl[7]  = mk(0, 0,          0, 0,            0,            1, 0, 0,            0, 0,          1);
    tbl[8]  = mk(0, 0,          1, 32'h00934505, 32'h20,       1, 0, 0,            0, 0,          1);
    tbl[9]  = mk(0, 0,          0, 0,            0,            1, 1, 32'h00004505, 1, 32'h20,     1);
    tbl[10] = mk(0, 0,          1, 32'h453100A0, 32'h24,       1, 0, 0,            0, 0,          1);
    tbl[11] = mk(0, 0,          0, 0,            0,            1, 1, 32'h00A00093, 0, 32'h22,     0);
    tbl[12] = mk(0, 0,          0, 0,            0,            1, 1, 32'h00004531, 1, 32'h26,     1);
    tbl[13] = mk(0, 0,          0, 0,            0,            1, 0, 0,            0, 0,          1);
    tbl[14] = mk(1, 32'h102,    1, 32'h12345678, 32'h28,       1, 0, 0,            0, 0,          0);
    tbl[15] = mk(0, 0,          1, 32'h0001DEAD, 32'h100,      1, 0, 0,            0, 0,          1);
    tbl[16] = mk(0, 0,          0, 0,            0,            1, 1, 32'h00000001, 1, 32'h102,    1);
    tbl[17] = mk(0, 0,          0, 0,            0,            1, 0, 0,            0, 0,          1);

    // Reset state
    #1;
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_inst", bus.out_inst, 32'h0);
    chk("rst_out_is_c", {31'h0, bus.out_is_c}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("row%0d", i));

    // Backpressure until full, then drain while the held word finally enters.
    apply(mk(0, 0, 1, 32'h00934505, 32'h200, 0, 0, 0, 0, 0, 1), "bp_push0");
    apply(mk(0, 0, 1, 32'h453100A0, 32'h204, 0, 1, 32'h4505, 1, 32'h200, 1), "bp_push1");
    apply(mk(0, 0, 1, 32'h00B00113, 32'h208, 0, 1, 32'h4505, 1, 32'h200, 0), "bp_full");
    apply(mk(0, 0, 1, 32'h00B00113, 32'h208, 1, 1, 32'h4505, 1, 32'h200, 0), "bp_drain0");
    apply(mk(0, 0, 1, 32'h00B00113, 32'h208, 1, 1, 32'h00A00093, 0, 32'h202, 0), "bp_drain1");
    apply(mk(0, 0, 1, 32'h00B00113, 32'h208, 1, 1, 32'h4531, 1, 32'h206, 1), "bp_pushpop");
    idle(1, 1, 32'h00B00113, 0, 32'h208, 1, "bp_last");
    idle(1, 0, 0, 0, 0, 1, "bp_empty");

    // Flush while valid and while a word is offered: no pop, word discarded.
    apply(mk(0, 0, 1, 32'h45014505, 32'h300, 1, 0, 0, 0, 0, 1), "fl_push");
    apply(mk(1, 32'h400, 1, 32'hFFFFFFFF, 32'h304, 1, 1, 32'h4505, 1, 32'h300, 0), "fl_cycle");
    chk("fl_head_pc", bus.out_pc, 32'h400);
    apply(mk(0, 0, 1, 32'h45014505, 32'h400, 1, 0, 0, 0, 0, 1), "fl_refill");
    idle(1, 1, 32'h4505, 1, 32'h400, 1, "fl_out0");
    idle(1, 1, 32'h4501, 1, 32'h402, 1, "fl_out1");
    idle(1, 0, 0, 0, 0, 1, "fl_empty");

    // head_pc wraps past the top of the address space.
    apply(mk(1, 32'hFFFFFFFE, 0, 0, 0, 1, 0, 0, 0, 0, 0), "wr_flush");
    apply(mk(0, 0, 1, 32'h4505DEAD, 32'hFFFFFFFC, 1, 0, 0, 0, 0, 1), "wr_push");
    idle(1, 1, 32'h4505, 1, 32'hFFFFFFFE, 1, "wr_out");
    chk("wr_wrapped_pc", bus.out_pc, 32'h0);
    chk("wr_empty", {31'h0, bus.out_valid}, 32'h0);

    // Asynchronous reset mid-stream with three halfwords queued.
    apply(mk(0, 0, 1, 32'h00934505, 32'h500, 0, 0, 0, 0, 0, 1), "rs_push0");
    apply(mk(0, 0, 1, 32'h453100A0, 32'h504, 1, 1, 32'h4505, 1, 32'h500, 1), "rs_push1");
    bus.in_valid = 0; bus.out_ready = 0;
    #1;
    chk("rs_cnt3_in_ready", {31'h0, bus.in_ready}, 32'h0);
    chk("rs_cnt3_inst", bus.out_inst, 32'h00A00093);
    chk("rs_cnt3_pc", bus.out_pc, 32'h502);
    #1 rst_n = 1'b0;
    #1;
    chk("rs_async_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rs_async_in_ready", {31'h0, bus.in_ready}, 32'h1);
    chk("rs_async_pc", bus.out_pc, 32'h0);
    @(posedge clk); #1;
    chk("rs_next_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rs_next_in_ready", {31'h0, bus.in_ready}, 32'h1);
    chk("rs_next_pc", bus.out_pc, 32'h0);
    rst_n = 1'b1;
    idle(1, 0, 0, 0, 0, 1, "rs_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
